// File: rtl/fir_stream_ctrl.sv
// Sequences coefficient loading and per-frame zero flushing in front of a FIR datapath.
// RUN is a combinational pass-through; FLUSH injects NTAPS-1 zero beats and stalls on f_ready.
module fir_stream_ctrl #(
    parameter int DATA_W = 16,
    parameter int NTAPS  = 8,
    parameter int IDX_W  = 3,
    parameter int CNT_W  = 16
) (
    input  logic              axi_clk,
    input  logic              axi_reset_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic              s_axis_valid,
    output logic              s_axis_ready,
    input  logic [DATA_W-1:0] s_axis_data,
    input  logic              s_axis_last,
    output logic              f_valid,
    input  logic              f_ready,
    output logic [DATA_W-1:0] f_data,
    output logic              coef_we,
    output logic [IDX_W-1:0]  coef_idx,
    output logic [DATA_W-1:0] coef_data,
    input  logic              ctrl_stop,
    output logic              m_axis_last,
    output logic              busy,
    output logic [CNT_W-1:0]  frame_cnt
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, FLUSH} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NTAPS - 1);
    localparam logic [IDX_W-1:0] FLUSH_LAST = IDX_W'(NTAPS - 2);

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] load_idx;
    logic [IDX_W-1:0] flush_cnt;
    logic             stop_pending;
    logic             stop_eff;
    logic             flush_done;

    // A stop raised in the very cycle the flush completes still counts.
    assign stop_eff   = stop_pending | ctrl_stop;
    assign flush_done = (state == FLUSH) && f_ready && (flush_cnt == FLUSH_LAST);

    assign coef_we   = cfg_valid & cfg_ready;
    assign coef_idx  = load_idx;
    assign coef_data = cfg_data;
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt    = state;
        cfg_ready    = 1'b0;
        s_axis_ready = 1'b0;
        f_valid      = 1'b0;
        f_data       = '0;
        case (state)
            IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) state_nxt = LOAD;
            end
            LOAD: begin
                cfg_ready = 1'b1;
                if (cfg_valid && (load_idx == LAST_IDX)) state_nxt = RUN;
            end
            RUN: begin
                f_valid      = s_axis_valid;
                f_data       = s_axis_data;
                s_axis_ready = f_ready;
                if (s_axis_valid && f_ready && s_axis_last) state_nxt = FLUSH;
            end
            FLUSH: begin
                f_valid = 1'b1;
                if (flush_done) state_nxt = stop_eff ? IDLE : RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            state        <= IDLE;
            load_idx     <= '0;
            flush_cnt    <= '0;
            stop_pending <= 1'b0;
            m_axis_last  <= 1'b0;
            frame_cnt    <= '0;
        end else begin
            state       <= state_nxt;
            m_axis_last <= flush_done;
            if (coef_we) begin
                load_idx <= (load_idx == LAST_IDX) ? '0 : load_idx + 1'b1;
            end
            if ((state == FLUSH) && f_ready) begin
                flush_cnt <= flush_done ? '0 : flush_cnt + 1'b1;
            end
            if (flush_done) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
            if (flush_done && stop_eff) begin
                stop_pending <= 1'b0;
            end else if (ctrl_stop && ((state == RUN) || (state == FLUSH))) begin
                stop_pending <= 1'b1;
            end
        end
    end

endmodule

// File: doc/fir_stream_ctrl.md
FIR_STREAM_CTRL -- requirements
Module: fir_stream_ctrl

Interface
REQ-001 Parameter DATA_W, default 16: width of sample, coefficient and config words.
REQ-002 Parameter NTAPS, default 8: filter tap count; flush length is NTAPS-1.
REQ-003 Parameter IDX_W, default 3: coefficient index width, equal to clog2(NTAPS).
REQ-004 Parameter CNT_W, default 16: width of the frame counter.
REQ-005 axi_clk  in  1  clock; all logic is rising-edge.
REQ-006 axi_reset_n  in  1  reset, asynchronous, active-low.
REQ-007 cfg_valid / cfg_ready / cfg_data  in / out / in  1 / 1 / DATA_W  coefficient load stream, one coefficient per beat, tap 0 first.
REQ-008 s_axis_valid / s_axis_ready / s_axis_data / s_axis_last  in / out / in / in  1 / 1 / DATA_W / 1  upstream sample stream, last marks frame end.
REQ-009 f_valid / f_ready / f_data  out / in / out  1 / 1 / DATA_W  sample stream to FIR datapath slave port.
REQ-010 coef_we / coef_idx / coef_data  out / out / out  1 / IDX_W / DATA_W  coefficient write port to FIR datapath.
REQ-011 ctrl_stop  in  1  request return to IDLE at the next frame end.
REQ-012 m_axis_last  out  1  frame-end marker aligned with the FIR output beat of the final flush sample.
REQ-013 busy / frame_cnt  out / out  1 / CNT_W  state is not IDLE / count of completed frames.

Function
REQ-014 The FSM SHALL have four states: IDLE, LOAD, RUN, FLUSH.
REQ-015 IDLE: cfg_ready=1, s_axis_ready=0, f_valid=0; an accepted cfg beat SHALL write index 0 and move to LOAD.
REQ-016 LOAD: cfg_ready=1, s_axis_ready=0; each accepted cfg beat SHALL write the next index; acceptance of index NTAPS-1 SHALL move to RUN.
REQ-017 coef_we SHALL be combinational cfg_valid&cfg_ready, with coef_data=cfg_data and coef_idx = the current load index; no pending write is held.
REQ-018 RUN: cfg_ready=0; f_valid=s_axis_valid, f_data=s_axis_data, s_axis_ready=f_ready, all combinational pass-through.
REQ-019 RUN: an accepted beat (s_axis_valid&s_axis_ready) with s_axis_last=1 SHALL move to FLUSH on the next edge.
REQ-020 FLUSH: s_axis_ready=0, cfg_ready=0, f_valid=1, f_data=0; a counter SHALL count accepted beats (f_valid&f_ready) from 0 to NTAPS-2.
REQ-021 FLUSH: f_ready=0 SHALL hold the flush counter and state; beats are never dropped.
REQ-022 On the edge accepting flush beat NTAPS-2, the FSM SHALL go to IDLE if stop is pending, else RUN; frame_cnt SHALL increment, wrapping modulo 2^CNT_W.
REQ-023 m_axis_last SHALL be a registered one-cycle pulse asserted in the cycle after the final flush beat is accepted, coinciding with the FIR output of that beat.
REQ-024 ctrl_stop=1 in any cycle in RUN or FLUSH SHALL set stop_pending; it SHALL clear on entry to IDLE; ctrl_stop has no effect in IDLE or LOAD.
REQ-025 cfg_valid in RUN or FLUSH SHALL be ignored: no coef_we, no state change.
REQ-026 A frame with s_axis_last on its first beat SHALL still produce a full NTAPS-1 beat flush.
REQ-027 busy SHALL be 1 in LOAD, RUN and FLUSH, and 0 in IDLE.

Reset
REQ-028 Reset SHALL force IDLE, load index 0, flush counter 0, stop_pending 0, m_axis_last 0, frame_cnt 0.
REQ-029 Reset mid-LOAD or mid-FLUSH SHALL abandon the operation without further coef_we or f_valid; previously written coefficients are not cleared.
REQ-030 Deassertion of reset SHALL take effect at the next axi_clk rising edge.

Verification
REQ-031 Load cfg words 1..8 back-to-back -> 8 coef_we pulses, idx 0..7, data 1..8; RUN one cycle after the 8th; busy=1.
REQ-032 In RUN, send samples 5, 6, 7 with last on 7 -> f_data 5, 6, 7 then 7 zero beats; m_axis_last pulses once, one cycle after the 7th zero; frame_cnt=1; s_axis_ready=0 throughout flush.
REQ-033 f_ready=0 for 3 cycles after the 2nd flush beat -> counter holds at 2; resumes; exactly 7 zero beats total.
REQ-034 ctrl_stop pulsed mid-frame -> frame completes and flushes, then IDLE; busy=0; s_axis_ready=0; cfg_valid during RUN produced no coef_we.
REQ-035 Reset asserted after 3 cfg beats -> IDLE, busy=0; a new load restarts at idx 0.
REQ-036 Drive 65536 one-beat frames -> frame_cnt wraps to 0; each frame has a full 7-beat flush.
